// File: rtl/param_fifo_rr_sched.sv
// param_fifo_rr_sched
// Round-robin read scheduler that drains NUM_CH param_fifo instances into a
// single valid/ready stream. Each word is tagged with its source channel.
// A channel holds the grant for up to MAX_BURST words.
// RD_LATENCY selects the FIFO read latency: 0 = REG_OUT off, 1 = REG_OUT on.
// Optional feature macro PARAM_FIFO_SCHED_STATS_EN adds the accepted-word and
// grant counters on the ports words_total and grants_total.
module param_fifo_rr_sched #(
    parameter int WIDTH_DATA = 8,
    parameter int NUM_CH     = 4,
    parameter int MAX_BURST  = 4,
    parameter int RD_LATENCY = 0,
    localparam int CW = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_empty,
    output logic [NUM_CH-1:0]            ch_rd_en,
    input  logic [NUM_CH*WIDTH_DATA-1:0] ch_rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH_DATA-1:0]        out_data,
    output logic [CW-1:0]                out_ch,
    output logic                         busy
`ifdef PARAM_FIFO_SCHED_STATS_EN
    ,
    output logic [31:0]                  words_total,
    output logic [31:0]                  grants_total
`endif
);

    localparam int BW = ($clog2(MAX_BURST) > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [CW-1:0]         grant_ch;
    logic [CW-1:0]         last_grant;
    logic [BW-1:0]         burst_cnt;

    logic                  sel_valid;
    logic [CW-1:0]         sel_ch;

    logic [WIDTH_DATA-1:0] ch_word [NUM_CH];

    logic                  issue;
    logic                  credit_ok;
    logic                  pop;
    logic                  push;
    logic                  inflight;
    logic [CW-1:0]         push_ch;
    logic [WIDTH_DATA-1:0] push_data;
    logic [2:0]            level;

    // Two-entry output buffer of {channel, data}.
    logic [WIDTH_DATA-1:0] buf_data [2];
    logic [CW-1:0]         buf_ch   [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_word[i] = ch_rd_data[i*WIDTH_DATA +: WIDTH_DATA];
    end

    // Pick the first non-empty channel after the previous grant, with wrap-around.
    always_comb begin
        int            idx;
        logic [CW-1:0] cand;
        // NOTE: every variable gets a default before any condition so no latch is inferred.
        sel_valid = 1'b0;
        sel_ch    = '0;
        idx       = 0;
        cand      = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx  = (int'(last_grant) + i) % NUM_CH;
            cand = CW'(idx);
            if (!sel_valid && !ch_empty[cand]) begin
                sel_valid = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    // A read may start only when the buffer has room for it after this cycle's
    // pop and after any read still in the latency pipe has landed.
    assign pop       = out_valid && out_ready;
    assign level     = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight};
    assign credit_ok = (level < 3'd2);
    assign issue     = (state == BURST) && !ch_empty[grant_ch] && credit_ok;

    // One-hot read strobe toward the granted FIFO.
    always_comb begin
        ch_rd_en           = '0;
        ch_rd_en[grant_ch] = issue;
    end

    // Arbitration and burst control FSM.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            grant_ch   <= '0;
            last_grant <= CW'(NUM_CH - 1);
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant_ch   <= sel_ch;
                        last_grant <= sel_ch;
                        burst_cnt  <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (issue) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if ((issue && (burst_cnt == BW'(MAX_BURST - 1))) || ch_empty[grant_ch]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if (RD_LATENCY == 0) begin : g_lat0
        // Combinational FIFO output: the word is valid in the issue cycle.
        assign push      = issue;
        assign push_ch   = grant_ch;
        assign push_data = ch_word[grant_ch];
        assign inflight  = 1'b0;
    end else begin : g_lat1
        logic          pipe_valid;
        logic [CW-1:0] pipe_ch;

        // Remember which channel was read so its registered data is captured next cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipe_valid <= 1'b0;
                pipe_ch    <= '0;
            end else begin
                pipe_valid <= issue;
                pipe_ch    <= grant_ch;
            end
        end

        assign push      = pipe_valid;
        assign push_ch   = pipe_ch;
        assign push_data = ch_word[pipe_ch];
        assign inflight  = pipe_valid;
    end

    // Output buffer: write at wr_ptr, read at rd_ptr, occupancy tracks both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the entries are reset too, so out_data/out_ch read 0 while in reset.
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_ch[i]   <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= push_data;
                buf_ch[wr_ptr]   <= push_ch;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = buf_data[rd_ptr];
    assign out_ch    = buf_ch[rd_ptr];
    assign busy      = (state != IDLE) || inflight || (occ != 2'd0);

`ifdef PARAM_FIFO_SCHED_STATS_EN
    // Accepted-word and grant counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_total  <= '0;
            grants_total <= '0;
        end else begin
            words_total  <= words_total + 32'(pop);
            grants_total <= grants_total + 32'((state == IDLE) && sel_valid);
        end
    end
`endif

endmodule

// File: tb/tb_param_fifo_rr_sched.sv
// Bench for param_fifo_rr_sched: one instance at RD_LATENCY=0 and one at
// RD_LATENCY=1 run the same directed scenarios. Each instance gets its own
// FIFO model and its own expected output stream.
module tb_param_fifo_rr_sched;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic out_ready = 1'b0;

    logic [N-1:0]   emp [2];
    logic [N*W-1:0] rdat0, rdat1;
    logic [N-1:0]   rden0, rden1;
    logic           ov0, ov1, busy0, busy1;
    logic [W-1:0]   od0, od1;
    logic [1:0]     oc0, oc1;
`ifdef PARAM_FIFO_SCHED_STATS_EN
    logic [31:0]    wt0, gt0, wt1, gt1;
`endif

    param_fifo_rr_sched #(.WIDTH_DATA(W), .NUM_CH(N), .MAX_BURST(MB), .RD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .ch_empty(emp[0]), .ch_rd_en(rden0), .ch_rd_data(rdat0),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ch(oc0), .busy(busy0)
`ifdef PARAM_FIFO_SCHED_STATS_EN
        , .words_total(wt0), .grants_total(gt0)
`endif
    );

    param_fifo_rr_sched #(.WIDTH_DATA(W), .NUM_CH(N), .MAX_BURST(MB), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .ch_empty(emp[1]), .ch_rd_en(rden1), .ch_rd_data(rdat1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ch(oc1), .busy(busy1)
`ifdef PARAM_FIFO_SCHED_STATS_EN
        , .words_total(wt1), .grants_total(gt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] rd_en;
        logic         valid;
        logic [1:0]   ch;
        logic [W-1:0] data;
        logic         busy;
    } snap_t;

    int n_cmp = 0;
    int n_bad = 0;

    // FIFO contents per lane and channel (index lane*N + ch), head at [0].
    logic [W-1:0] fq [2*N][$];
    // Expected output stream per lane, {ch, data}.
    logic [9:0]   expq [2][$];
    int           model_last [2];

    int   rd_cnt [2][N];
    int   accepted [2];
    bit   hold_v [2];
    logic [9:0] hold_w [2];
    int   cur_ch [2];
    int   cur_len [2];
    int   runs [2][$];
    int   cyc = 0;
    int   first_rd [2];
    int   last_rd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic snap_t snap(input int l);
        snap_t s;
        if (l == 0) s = '{rden0, ov0, oc0, od0, busy0};
        else        s = '{rden1, ov1, oc1, od1, busy1};
        return s;
    endfunction

    // Drive empty flags and the show-ahead data of the latency-0 FIFOs.
    task automatic refresh();
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < N; c++)
                emp[l][c] = (fq[l*N+c].size() == 0);
        for (int c = 0; c < N; c++)
            rdat0[c*W +: W] = (fq[c].size() != 0) ? fq[c][0] : '0;
    endtask

    task automatic load(input int c, input int n, input logic [W-1:0] base);
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < n; i++)
                fq[l*N+c].push_back(base + W'(i));
        refresh();
    endtask

    // Round-robin draining of a static set of FIFO contents: the next non-empty
    // channel after the previous grant gives up to MB words, in FIFO order.
    task automatic build_expected(input int l);
        int ptr [N];
        int c;
        int found;
        int k;
        for (int i = 0; i < N; i++) ptr[i] = 0;
        do begin
            found = -1;
            for (int i = 1; i <= N; i++) begin
                c = (model_last[l] + i) % N;
                if (found < 0 && ptr[c] < fq[l*N+c].size()) found = c;
            end
            if (found >= 0) begin
                k = 0;
                while (k < MB && ptr[found] < fq[l*N+found].size()) begin
                    expq[l].push_back({2'(found), fq[l*N+found][ptr[found]]});
                    ptr[found]++;
                    k++;
                end
                model_last[l] = found;
            end
        end while (found >= 0);
    endtask

    task automatic reset_model();
        for (int l = 0; l < 2; l++) begin
            expq[l].delete();
            hold_v[l]     = 1'b0;
            model_last[l] = N - 1;
            cur_len[l]    = 0;
            runs[l].delete();
        end
    endtask

    task automatic clear_stats();
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < N; c++) rd_cnt[l][c] = 0;
            accepted[l] = 0;
            first_rd[l] = -1;
            last_rd[l]  = -1;
            cur_len[l]  = 0;
            runs[l].delete();
        end
    endtask

    task automatic flush_run(input int l);
        if (cur_len[l] > 0) runs[l].push_back(cur_ch[l] * 100 + cur_len[l]);
        cur_len[l] = 0;
    endtask

    // Per-cycle comparison of both instances against the model.
    task automatic compare_cycle();
        snap_t s;
        logic [9:0] e;
        for (int l = 0; l < 2; l++) begin
            s = snap(l);
            check($sformatf("rd_en_onehot[lat%0d]", l), 32'($countones(s.rd_en) <= 1), 32'd1);
            check($sformatf("rd_en_on_empty[lat%0d]", l), 32'(s.rd_en & emp[l]), 32'd0);
            for (int c = 0; c < N; c++) rd_cnt[l][c] += int'(s.rd_en[c]);
            if (s.rd_en != '0) begin
                if (first_rd[l] < 0) first_rd[l] = cyc;
                last_rd[l] = cyc;
            end
            if (hold_v[l]) begin
                check($sformatf("hold_valid[lat%0d]", l), 32'(s.valid), 32'd1);
                check($sformatf("hold_word[lat%0d]", l), {22'b0, s.ch, s.data}, {22'b0, hold_w[l]});
            end
            if (s.valid && out_ready) begin
                check($sformatf("word_expected[lat%0d]", l), 32'(expq[l].size() != 0), 32'd1);
                if (expq[l].size() != 0) begin
                    e = expq[l].pop_front();
                    check($sformatf("out_word[lat%0d]", l), {22'b0, s.ch, s.data}, {22'b0, e});
                end
                accepted[l]++;
                if (cur_len[l] > 0 && int'(s.ch) == cur_ch[l]) begin
                    cur_len[l]++;
                end else begin
                    flush_run(l);
                    cur_ch[l]  = int'(s.ch);
                    cur_len[l] = 1;
                end
            end
            hold_v[l] = s.valid && !out_ready;
            hold_w[l] = {s.ch, s.data};
        end
    endtask

    // FIFO model update for the reads seen in the cycle just ended.
    task automatic fifo_update(input logic [N-1:0] r0, input logic [N-1:0] r1);
        logic [N-1:0] rs [2];
        logic [W-1:0] w;
        rs[0] = r0;
        rs[1] = r1;
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < N; c++)
                if (rs[l][c] && fq[l*N+c].size() != 0) begin
                    w = fq[l*N+c].pop_front();
                    if (l == 1) rdat1[c*W +: W] = w;
                end
        refresh();
    endtask

    task automatic tick();
        logic [N-1:0] r0, r1;
        @(negedge clk);
        compare_cycle();
        r0 = rden0;
        r1 = rden1;
        @(posedge clk);
        #1;
        cyc++;
        fifo_update(r0, r1);
    endtask

    function automatic bit all_idle();
        bit ok;
        ok = (expq[0].size() == 0) && (expq[1].size() == 0) && !busy0 && !busy1;
        for (int i = 0; i < 2*N; i++) if (fq[i].size() != 0) ok = 1'b0;
        return ok;
    endfunction

    task automatic drain(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = all_idle();
        end
        check({tag, "_drained"}, 32'(done), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        snap_t s;
        for (int l = 0; l < 2; l++) begin
            s = snap(l);
            check($sformatf("%s_rd_en[lat%0d]", tag, l), 32'(s.rd_en), 32'd0);
            check($sformatf("%s_valid[lat%0d]", tag, l), 32'(s.valid), 32'd0);
            check($sformatf("%s_data[lat%0d]", tag, l), 32'(s.data), 32'd0);
            check($sformatf("%s_ch[lat%0d]", tag, l), 32'(s.ch), 32'd0);
            check($sformatf("%s_busy[lat%0d]", tag, l), 32'(s.busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t, want < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_runs_a [6];
        int exp_runs_c [3];
        snap_t s;
        exp_runs_a = '{4, 104, 4, 104, 2, 102};
        exp_runs_c = '{4, 302, 1};
        rdat0 = '0;
        rdat1 = '0;
        reset_model();
        clear_stats();
        refresh();

        // Reset with every FIFO empty.
        #1 rst = 1'b1;
        #1 check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        for (int l = 0; l < 2; l++) begin
            s = snap(l);
            check($sformatf("idle_valid[lat%0d]", l), 32'(s.valid), 32'd0);
            check($sformatf("idle_busy[lat%0d]", l), 32'(s.busy), 32'd0);
            check($sformatf("idle_reads[lat%0d]", l),
                  32'(rd_cnt[l][0] + rd_cnt[l][1] + rd_cnt[l][2] + rd_cnt[l][3]), 32'd0);
        end

        // Only channel 2 holds three words.
        clear_stats();
        load(2, 3, 8'h21);
        build_expected(0);
        build_expected(1);
        drain("ch2_only", 60);
        for (int l = 0; l < 2; l++) begin
            check($sformatf("ch2_reads[lat%0d]", l), 32'(rd_cnt[l][2]), 32'd3);
            check($sformatf("ch2_accepted[lat%0d]", l), 32'(accepted[l]), 32'd3);
            check($sformatf("ch2_busy_end[lat%0d]", l), 32'(snap(l).busy), 32'd0);
        end

        // Channels 0 and 1 with ten words each: bursts 4,4,4,4,2,2 at full rate.
        clear_stats();
        load(0, 10, 8'h40);
        load(1, 10, 8'h80);
        build_expected(0);
        build_expected(1);
        drain("two_ch", 200);
        for (int l = 0; l < 2; l++) begin
            flush_run(l);
            check($sformatf("two_ch_runs[lat%0d]", l), 32'(runs[l].size()), 32'd6);
            for (int i = 0; i < 6 && i < runs[l].size(); i++)
                check($sformatf("two_ch_run%0d[lat%0d]", i, l), 32'(runs[l][i]), 32'(exp_runs_a[i]));
            check($sformatf("two_ch_read_span[lat%0d]", l), 32'(last_rd[l] - first_rd[l] + 1), 32'd26);
        end

        // Sink stalled for 20 cycles with ten words waiting on channel 0.
        clear_stats();
        out_ready = 1'b0;
        load(0, 10, 8'hA0);
        build_expected(0);
        build_expected(1);
        repeat (20) tick();
        for (int l = 0; l < 2; l++) begin
            s = snap(l);
            check($sformatf("stall_reads[lat%0d]", l), 32'(rd_cnt[l][0]), 32'd2);
            check($sformatf("stall_valid[lat%0d]", l), 32'(s.valid), 32'd1);
            check($sformatf("stall_head[lat%0d]", l), {22'b0, s.ch, s.data}, 32'h0A0);
        end
        out_ready = 1'b1;
        drain("stall", 200);
        for (int l = 0; l < 2; l++)
            check($sformatf("stall_accepted[lat%0d]", l), 32'(accepted[l]), 32'd10);

        // Reset in the middle of a channel 3 burst.
        clear_stats();
        load(3, 8, 8'hC0);
        build_expected(0);
        build_expected(1);
        repeat (3) tick();
        check("pre_reset_rd_en[lat0]", 32'(rden0), 32'h8);
        check("pre_reset_rd_en[lat1]", 32'(rden1), 32'h8);
        #1 rst = 1'b1;
        #1 check_zero("mid_reset");
        reset_model();
        clear_stats();
        load(1, 2, 8'h51);
        load(2, 2, 8'h61);
        tick();
        tick();
        rst = 1'b0;
        build_expected(0);
        build_expected(1);
        drain("after_reset", 200);
        for (int l = 0; l < 2; l++) begin
            flush_run(l);
            check($sformatf("after_reset_first_run[lat%0d]", l),
                  32'((runs[l].size() != 0) ? runs[l][0] : -1), 32'd102);
        end

        // Seven words over three grants after a fresh reset.
        #1 rst = 1'b1;
        reset_model();
        clear_stats();
        tick();
        rst = 1'b0;
        load(0, 5, 8'h70);
        load(3, 2, 8'hE0);
        build_expected(0);
        build_expected(1);
        drain("stats", 200);
        for (int l = 0; l < 2; l++) begin
            flush_run(l);
            check($sformatf("stats_accepted[lat%0d]", l), 32'(accepted[l]), 32'd7);
            check($sformatf("stats_runs[lat%0d]", l), 32'(runs[l].size()), 32'd3);
            for (int i = 0; i < 3 && i < runs[l].size(); i++)
                check($sformatf("stats_run%0d[lat%0d]", i, l), 32'(runs[l][i]), 32'(exp_runs_c[i]));
        end
`ifdef PARAM_FIFO_SCHED_STATS_EN
        check("words_total[lat0]", wt0, 32'd7);
        check("grants_total[lat0]", gt0, 32'd3);
        check("words_total[lat1]", wt1, 32'd7);
        check("grants_total[lat1]", gt1, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
